// File: rtl/gomoku_pkg.sv
// gomoku_pkg: shared definitions for the grid-game turn controller.
//   - gtc_state_e   : game FSM state codes (also exported on state_out)
//   - JUDGE_*       : judge_result encoding returned by the external judger
//   - EMPTY_CELL    : board RAM value of an unoccupied cell
package gomoku_pkg;

    typedef enum logic [2:0] {
        ST_STOPPED = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_JUDGE   = 3'd3,
        ST_COMMIT  = 3'd4,
        ST_END     = 3'd5
    } gtc_state_e;

    localparam logic [1:0] JUDGE_INVALID = 2'd0;
    localparam logic [1:0] JUDGE_VALID   = 2'd1;
    localparam logic [1:0] JUDGE_WIN     = 2'd2;

    localparam int unsigned EMPTY_CELL = 0;

endpackage

// File: rtl/gtc_countdown.sv
// gtc_countdown: per-turn seconds countdown.
// Ports:
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   reload     : load TURN_SECONDS (wins over tick)
//   tick       : decrement by one, holding at zero
//   count      : seconds remaining
//   zero       : count == 0
module gtc_countdown #(
    parameter  int unsigned TURN_SECONDS = 20,
    localparam int unsigned C            = $clog2(TURN_SECONDS + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         reload,
    input  logic         tick,
    output logic [C-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (reload) begin
            count <= C'(TURN_SECONDS);
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: turn/score controller for gomoku-family grid games.
// Owns the game FSM, turn countdown, keypad cursor capture, judge handshake,
// board-RAM write strobe and per-player win scores.
// Optional feature macro: GTC_UNDO_EN adds btn_undo and a one-level undo.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   power, btn_reset         : level controls (power low > btn_reset > FSM)
//   btn_ok                   : raw commit button, synchronised + edge detected
//   btn_undo (GTC_UNDO_EN)   : raw undo button, synchronised + edge detected
//   sec_tick                 : one-cycle pulse per second
//   key_valid, key_code      : keypad event, key_code MSB 1 = x axis, 0 = y axis
//   key_ack                  : registered acknowledge, cycle after key_valid
//   clear_req, clear_done    : memory clear handshake
//   judge_req/pos/player     : move under judgement, judge_done/result back
//   ram_we/addr/data         : board write, data = player+1, 0 = empty
//   state_out, active_player : FSM state code and player to move
//   cursor_pos, cursor_valid : {y, x} cursor, valid when both axes entered
//   countdown                : seconds remaining in the turn
//   scores                   : player i at [i*SCORE_BITS +: SCORE_BITS]
//   piece_count, draw        : pieces on board, board filled without a win
module game_turn_controller
    import gomoku_pkg::*;
#(
    parameter  int unsigned EDGE_BITS    = 3,
    parameter  int unsigned NUM_PLAYERS  = 2,
    parameter  int unsigned TURN_SECONDS = 20,
    parameter  int unsigned SCORE_BITS   = 4,
    localparam int unsigned A            = 2 * EDGE_BITS,
    localparam int unsigned P            = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int unsigned C            = $clog2(TURN_SECONDS + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              power,
    input  logic                              btn_reset,
    input  logic                              btn_ok,
`ifdef GTC_UNDO_EN
    input  logic                              btn_undo,
`endif
    input  logic                              sec_tick,
    input  logic                              key_valid,
    input  logic [EDGE_BITS:0]                key_code,
    output logic                              key_ack,
    output logic                              clear_req,
    input  logic                              clear_done,
    output logic                              judge_req,
    output logic [A-1:0]                      judge_pos,
    output logic [P-1:0]                      judge_player,
    input  logic                              judge_done,
    input  logic [1:0]                        judge_result,
    output logic                              ram_we,
    output logic [A-1:0]                      ram_addr,
    output logic [P:0]                        ram_data,
    output logic [2:0]                        state_out,
    output logic [P-1:0]                      active_player,
    output logic [A-1:0]                      cursor_pos,
    output logic                              cursor_valid,
    output logic [C-1:0]                      countdown,
    output logic [NUM_PLAYERS*SCORE_BITS-1:0] scores,
    output logic [A:0]                        piece_count,
    output logic                              draw
);

    localparam logic [A:0] LAST_FILL = (A+1)'((1 << A) - 1);

    gtc_state_e           state, next_state;
    logic [P-1:0]         player;
    logic [EDGE_BITS-1:0] cur_x, cur_y;
    logic                 x_set, y_set;
    logic [1:0]           verdict;
    logic [2:0]           ok_sync;
    logic                 ok_edge;
    logic                 cd_zero, cd_reload, cd_tick;

    // FSM strobes consumed by the datapath register block
    logic start_game, do_commit, do_pass, judge_accept, judge_invalid;
    logic do_undo, cursor_we;

    logic                 undo_phase;
    logic [A-1:0]         undo_addr;
    logic [P-1:0]         undo_player;

    function automatic logic [P-1:0] next_player(input logic [P-1:0] p);
        return (32'(p) == NUM_PLAYERS - 1) ? '0 : p + 1'b1;
    endfunction

    assign cursor_pos   = {cur_y, cur_x};
    assign cursor_valid = x_set & y_set;
    assign ok_edge      = ok_sync[1] & ~ok_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ok_sync <= '0;
        else        ok_sync <= {ok_sync[1:0], btn_ok};
    end

`ifdef GTC_UNDO_EN
    logic [2:0] undo_sync;
    logic       undo_edge, undo_held;

    assign undo_edge = undo_sync[1] & ~undo_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            undo_sync   <= '0;
            undo_held   <= 1'b0;
            undo_phase  <= 1'b0;
            undo_addr   <= '0;
            undo_player <= '0;
        end else begin
            undo_sync <= {undo_sync[1:0], btn_undo};
            if (state == ST_COMMIT && !undo_phase) begin
                undo_held   <= 1'b1;
                undo_addr   <= cursor_pos;
                undo_player <= player;
            end
            if (state == ST_COMMIT) undo_phase <= 1'b0;
            if (do_undo) begin
                undo_phase <= 1'b1;
                undo_held  <= 1'b0;
            end
            if (state == ST_CLEAR || next_state == ST_END) undo_held <= 1'b0;
        end
    end
`else
    // Undo disabled: constant ties keep the commit path shared with the undo build.
    assign undo_phase  = 1'b0;
    assign undo_addr   = '0;
    assign undo_player = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_STOPPED;
        else        state <= next_state;
    end

    always_comb begin
        next_state    = state;
        start_game    = 1'b0;
        do_commit     = 1'b0;
        do_pass       = 1'b0;
        judge_accept  = 1'b0;
        judge_invalid = 1'b0;
        do_undo       = 1'b0;
        cursor_we     = 1'b0;
        if (!power) begin
            next_state = ST_STOPPED;
        end else if (btn_reset) begin
            next_state = ST_CLEAR;
        end else begin
            case (state)
                ST_STOPPED: next_state = ST_CLEAR;
                ST_CLEAR: if (clear_done) begin
                    next_state = ST_WAIT;
                    start_game = 1'b1;
                end
                ST_WAIT: begin
                    // cursor is frozen on the commit cycle so the judge sees the pre-key value
                    if (cursor_valid && (ok_edge || (sec_tick && cd_zero))) begin
                        next_state = ST_JUDGE;
                        do_commit  = 1'b1;
                    end else if (sec_tick && cd_zero) begin
                        do_pass = 1'b1;
`ifdef GTC_UNDO_EN
                    end else if (undo_edge && undo_held) begin
                        next_state = ST_COMMIT;
                        do_undo    = 1'b1;
`endif
                    end else begin
                        cursor_we = key_valid;
                    end
                end
                ST_JUDGE: if (judge_done) begin
                    if (judge_result == JUDGE_VALID || judge_result == JUDGE_WIN) begin
                        next_state   = ST_COMMIT;
                        judge_accept = 1'b1;
                    end else begin
                        next_state    = ST_WAIT;
                        judge_invalid = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (undo_phase)                    next_state = ST_WAIT;
                    else if (verdict == JUDGE_WIN)     next_state = ST_END;
                    else if (piece_count == LAST_FILL) next_state = ST_END;
                    else                               next_state = ST_WAIT;
                end
                ST_END:  next_state = ST_END;
                default: next_state = ST_STOPPED;
            endcase
        end
    end

    assign cd_reload = (next_state == ST_WAIT) && (state != ST_WAIT || do_pass);
    assign cd_tick   = (state == ST_WAIT) && sec_tick;

    gtc_countdown #(
        .TURN_SECONDS(TURN_SECONDS)
    ) u_countdown (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (cd_reload),
        .tick   (cd_tick),
        .count  (countdown),
        .zero   (cd_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ack     <= 1'b0;
            player      <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            x_set       <= 1'b0;
            y_set       <= 1'b0;
            verdict     <= JUDGE_INVALID;
            piece_count <= '0;
            draw        <= 1'b0;
            scores      <= '0;
        end else begin
            key_ack <= key_valid;
            if (cursor_we) begin
                if (key_code[EDGE_BITS]) begin
                    cur_x <= key_code[EDGE_BITS-1:0];
                    x_set <= 1'b1;
                end else begin
                    cur_y <= key_code[EDGE_BITS-1:0];
                    y_set <= 1'b1;
                end
            end
            if (start_game) begin
                player      <= '0;
                piece_count <= '0;
                draw        <= 1'b0;
                x_set       <= 1'b0;
                y_set       <= 1'b0;
            end
            if (do_pass) begin
                player <= next_player(player);
                x_set  <= 1'b0;
                y_set  <= 1'b0;
            end
            if (judge_invalid || do_undo) begin
                x_set <= 1'b0;
                y_set <= 1'b0;
            end
            if (judge_accept) verdict <= judge_result;
            if (state == ST_COMMIT) begin
                x_set <= 1'b0;
                y_set <= 1'b0;
                if (undo_phase) begin
                    piece_count <= piece_count - 1'b1;
                    player      <= undo_player;
                end else begin
                    piece_count <= piece_count + 1'b1;
                    if (verdict == JUDGE_WIN) begin
                        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
                            if (P'(i) == player && scores[i*SCORE_BITS +: SCORE_BITS] != '1)
                                scores[i*SCORE_BITS +: SCORE_BITS] <=
                                    scores[i*SCORE_BITS +: SCORE_BITS] + 1'b1;
                        end
                    end else if (piece_count == LAST_FILL) begin
                        draw <= 1'b1;
                    end else begin
                        player <= next_player(player);
                    end
                end
            end
        end
    end

    assign state_out     = state;
    assign active_player = player;
    assign clear_req     = (state == ST_CLEAR);
    assign judge_req     = (state == ST_JUDGE);
    assign judge_pos     = cursor_pos;
    assign judge_player  = player;

    // RAM port idles at zero outside COMMIT; the clearer owns RAM during CLEAR.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (state == ST_COMMIT) begin
            ram_we = 1'b1;
            if (undo_phase) begin
                ram_addr = undo_addr;
                ram_data = (P+1)'(EMPTY_CELL);
            end else begin
                ram_addr = cursor_pos;
                ram_data = {1'b0, player} + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: directed bench for game_turn_controller.
// dut_a: default 8x8 / 2 players; dut_b: 2x2 / 3 players for the draw
// (and undo when GTC_UNDO_EN is defined). Inputs are shared; each DUT has
// its own power so only the selected one plays.
module tb_game_turn_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, power_a, power_b, btn_reset, btn_ok, sec_tick;
    logic       key_valid, clear_done, judge_done;
    logic [3:0] key_code;
    logic [1:0] judge_result;
`ifdef GTC_UNDO_EN
    logic       btn_undo;
`endif
    bit         sel;
    int         checks = 0;
    int         failures = 0;
    int         we_cnt_a = 0;

    logic       a_key_ack, a_clear_req, a_judge_req, a_ram_we, a_cursor_valid, a_draw;
    logic [5:0] a_judge_pos, a_ram_addr, a_cursor_pos;
    logic [0:0] a_judge_player, a_player;
    logic [1:0] a_ram_data;
    logic [2:0] a_state;
    logic [4:0] a_countdown;
    logic [7:0] a_scores;
    logic [6:0] a_piece;

    logic        b_key_ack, b_clear_req, b_judge_req, b_ram_we, b_cursor_valid, b_draw;
    logic [1:0]  b_judge_pos, b_ram_addr, b_cursor_pos, b_judge_player, b_player;
    logic [2:0]  b_ram_data, b_state, b_piece;
    logic [4:0]  b_countdown;
    logic [11:0] b_scores;

    game_turn_controller dut_a (
        .clk(clk), .rst_n(rst_n), .power(power_a), .btn_reset(btn_reset), .btn_ok(btn_ok),
`ifdef GTC_UNDO_EN
        .btn_undo(btn_undo),
`endif
        .sec_tick(sec_tick), .key_valid(key_valid), .key_code(key_code), .key_ack(a_key_ack),
        .clear_req(a_clear_req), .clear_done(clear_done), .judge_req(a_judge_req),
        .judge_pos(a_judge_pos), .judge_player(a_judge_player), .judge_done(judge_done),
        .judge_result(judge_result), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_data(a_ram_data), .state_out(a_state), .active_player(a_player),
        .cursor_pos(a_cursor_pos), .cursor_valid(a_cursor_valid), .countdown(a_countdown),
        .scores(a_scores), .piece_count(a_piece), .draw(a_draw)
    );

    game_turn_controller #(
        .EDGE_BITS(1), .NUM_PLAYERS(3), .TURN_SECONDS(20), .SCORE_BITS(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .power(power_b), .btn_reset(btn_reset), .btn_ok(btn_ok),
`ifdef GTC_UNDO_EN
        .btn_undo(btn_undo),
`endif
        .sec_tick(sec_tick), .key_valid(key_valid), .key_code({key_code[3], key_code[0]}),
        .key_ack(b_key_ack), .clear_req(b_clear_req), .clear_done(clear_done),
        .judge_req(b_judge_req), .judge_pos(b_judge_pos), .judge_player(b_judge_player),
        .judge_done(judge_done), .judge_result(judge_result), .ram_we(b_ram_we),
        .ram_addr(b_ram_addr), .ram_data(b_ram_data), .state_out(b_state),
        .active_player(b_player), .cursor_pos(b_cursor_pos), .cursor_valid(b_cursor_valid),
        .countdown(b_countdown), .scores(b_scores), .piece_count(b_piece), .draw(b_draw)
    );

    logic [31:0] o_state, o_player, o_cursor_pos, o_cursor_valid, o_countdown, o_piece, o_draw;
    logic [31:0] o_ram_we, o_ram_addr, o_ram_data, o_judge_req, o_judge_pos, o_judge_player;
    logic [31:0] o_clear_req, o_key_ack;

    always_comb begin
        o_state        = sel ? 32'(b_state)        : 32'(a_state);
        o_player       = sel ? 32'(b_player)       : 32'(a_player);
        o_cursor_pos   = sel ? 32'(b_cursor_pos)   : 32'(a_cursor_pos);
        o_cursor_valid = sel ? 32'(b_cursor_valid) : 32'(a_cursor_valid);
        o_countdown    = sel ? 32'(b_countdown)    : 32'(a_countdown);
        o_piece        = sel ? 32'(b_piece)        : 32'(a_piece);
        o_draw         = sel ? 32'(b_draw)         : 32'(a_draw);
        o_ram_we       = sel ? 32'(b_ram_we)       : 32'(a_ram_we);
        o_ram_addr     = sel ? 32'(b_ram_addr)     : 32'(a_ram_addr);
        o_ram_data     = sel ? 32'(b_ram_data)     : 32'(a_ram_data);
        o_judge_req    = sel ? 32'(b_judge_req)    : 32'(a_judge_req);
        o_judge_pos    = sel ? 32'(b_judge_pos)    : 32'(a_judge_pos);
        o_judge_player = sel ? 32'(b_judge_player) : 32'(a_judge_player);
        o_clear_req    = sel ? 32'(b_clear_req)    : 32'(a_clear_req);
        o_key_ack      = sel ? 32'(b_key_ack)      : 32'(a_key_ack);
    end

    always @(negedge clk) if (a_ram_we === 1'b1) we_cnt_a++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input string name, input logic [31:0] target, input int max);
        for (int i = 0; i < max && o_state != target; i++) tick();
        check(name, o_state, target);
    endtask

    task automatic send_key(input bit x_axis, input int v);
        key_valid = 1'b1;
        key_code  = {x_axis, 3'(v)};
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press_ok();
        btn_ok = 1'b1;
        wait_state("ok_to_judge", 32'd3, 8);
        btn_ok = 1'b0;
        tick();
        tick();
    endtask

    task automatic give_judge(input logic [1:0] res);
        judge_done   = 1'b1;
        judge_result = res;
        tick();
        judge_done   = 1'b0;
        judge_result = 2'd0;
    endtask

    task automatic do_clear();
        wait_state("clear_entry", 32'd1, 4);
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
    endtask

    task automatic move(input int x, input int y, input logic [1:0] res);
        send_key(1'b1, x);
        send_key(1'b0, y);
        press_ok();
        give_judge(res);
    endtask

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic [5:0] exp_pos;
        logic       exp_valid;
        logic       exp_ack;
    } key_vec_t;

    key_vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b1, 4'hB, 6'h03, 1'b0, 1'b1};  // x = 3
        vecs[1] = '{1'b0, 4'h0, 6'h03, 1'b0, 1'b0};  // idle
        vecs[2] = '{1'b1, 4'h5, 6'h2B, 1'b1, 1'b1};  // y = 5
        vecs[3] = '{1'b1, 4'hF, 6'h2F, 1'b1, 1'b1};  // x = 7
        vecs[4] = '{1'b1, 4'hB, 6'h2B, 1'b1, 1'b1};  // x = 3

        sel = 1'b0; rst_n = 1'b0; power_a = 1'b0; power_b = 1'b0; btn_reset = 1'b0;
        btn_ok = 1'b0; sec_tick = 1'b0; key_valid = 1'b0; key_code = '0;
        clear_done = 1'b0; judge_done = 1'b0; judge_result = '0;
`ifdef GTC_UNDO_EN
        btn_undo = 1'b0;
`endif
        tick(); tick();
        check("rst_state", o_state, 0);
        check("rst_countdown", o_countdown, 0);
        check("rst_scores", 32'(a_scores), 0);
        check("rst_piece", o_piece, 0);
        check("rst_ram_we", o_ram_we, 0);
        check("rst_clear_req", o_clear_req, 0);
        rst_n = 1'b1;
        tick();

        power_a = 1'b1;
        tick();
        check("power_clear", o_state, 1);
        check("clear_req", o_clear_req, 1);
        repeat (4) tick();
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check("wait_state", o_state, 2);
        check("wait_player", o_player, 0);
        check("wait_countdown", o_countdown, 20);
        check("wait_cursor_valid", o_cursor_valid, 0);

        for (int i = 0; i < 5; i++) begin
            key_valid = vecs[i].kv;
            key_code  = vecs[i].code;
            tick();
            key_valid = 1'b0;
            check($sformatf("key%0d_pos", i), o_cursor_pos, 32'(vecs[i].exp_pos));
            check($sformatf("key%0d_valid", i), o_cursor_valid, 32'(vecs[i].exp_valid));
            check($sformatf("key%0d_ack", i), o_key_ack, 32'(vecs[i].exp_ack));
        end

        press_ok();
        check("judge_req", o_judge_req, 1);
        check("judge_pos", o_judge_pos, 32'h2B);
        check("judge_player", o_judge_player, 0);
        give_judge(2'd1);
        check("commit_state", o_state, 4);
        check("commit_we", o_ram_we, 1);
        check("commit_addr", o_ram_addr, 32'h2B);
        check("commit_data", o_ram_data, 1);
        tick();
        check("post_commit_state", o_state, 2);
        check("post_commit_player", o_player, 1);
        check("post_commit_piece", o_piece, 1);
        check("post_commit_we", o_ram_we, 0);
        check("ram_we_once", 32'(we_cnt_a), 1);

        move(1, 1, 2'd0);
        check("invalid_state", o_state, 2);
        check("invalid_player", o_player, 1);
        check("invalid_cursor", o_cursor_valid, 0);
        check("invalid_countdown", o_countdown, 20);
        tick();
        check("invalid_no_we", 32'(we_cnt_a), 1);

        for (int i = 0; i < 20; i++) begin
            sec_tick = 1'b1; tick(); sec_tick = 1'b0; tick();
            if (i == 0) check("countdown_19", o_countdown, 19);
        end
        check("countdown_0", o_countdown, 0);
        check("timeout_hold_player", o_player, 1);
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        check("timeout_pass_player", o_player, 0);
        check("timeout_reload", o_countdown, 20);
        check("timeout_state", o_state, 2);

        send_key(1'b1, 2);
        send_key(1'b0, 2);
        for (int i = 0; i < 20; i++) begin
            sec_tick = 1'b1; tick(); sec_tick = 1'b0; tick();
        end
        sec_tick = 1'b1; tick(); sec_tick = 1'b0;
        check("auto_judge_state", o_state, 3);
        check("auto_judge_pos", o_judge_pos, 32'h12);
        give_judge(2'd2);
        check("win_data", o_ram_data, 1);
        tick();
        check("win_end", o_state, 5);
        check("win_score0", 32'(a_scores), 32'h01);
        check("win_draw", o_draw, 0);

        // 16 wins for player 1: score climbs to 15 then saturates
        for (int g = 0; g < 16; g++) begin
            btn_reset = 1'b1; tick(); btn_reset = 1'b0;
            do_clear();
            move(0, 0, 2'd1);
            tick();
            move(1, 0, 2'd2);
            tick();
            check($sformatf("game%0d_end", g), o_state, 5);
            if (g == 14) check("score_at_15", 32'(a_scores), 32'hF1);
        end
        check("score_saturated", 32'(a_scores), 32'hF1);
        btn_reset = 1'b1;
        tick();
        check("end_reset_clear", o_state, 1);
        btn_reset = 1'b0;
        clear_done = 1'b1; tick(); clear_done = 1'b0;
        check("scores_kept", 32'(a_scores), 32'hF1);
        check("clear_piece", o_piece, 0);
        power_a = 1'b0;
        tick();
        check("power_off", o_state, 0);

        sel = 1'b1;
        power_b = 1'b1;
        tick();
        do_clear();
        check("b_wait", o_state, 2);
        check("b_countdown", o_countdown, 20);
        move(0, 0, 2'd1);
        check("b_m1_addr", o_ram_addr, 0);
        check("b_m1_data", o_ram_data, 1);
        tick();
        check("b_m1_player", o_player, 1);
        move(1, 0, 2'd1);
        check("b_m2_data", o_ram_data, 2);
        tick();
        move(0, 1, 2'd1);
        check("b_m3_addr", o_ram_addr, 2);
        check("b_m3_data", o_ram_data, 3);
        tick();
        check("b_m3_player", o_player, 0);
        check("b_m3_piece", o_piece, 3);
`ifdef GTC_UNDO_EN
        btn_undo = 1'b1;
        wait_state("undo_commit", 32'd4, 8);
        check("undo_we", o_ram_we, 1);
        check("undo_addr", o_ram_addr, 2);
        check("undo_data", o_ram_data, 0);
        btn_undo = 1'b0;
        tick();
        check("undo_state", o_state, 2);
        check("undo_player", o_player, 2);
        check("undo_piece", o_piece, 2);
        check("undo_countdown", o_countdown, 20);
        move(0, 1, 2'd1);
        tick();
`endif
        move(1, 1, 2'd1);
        check("b_m4_addr", o_ram_addr, 3);
        check("b_m4_data", o_ram_data, 1);
        tick();
        check("draw_end", o_state, 5);
        check("draw_flag", o_draw, 1);
        check("draw_piece", o_piece, 4);
        check("draw_scores", 32'(b_scores), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
